cbus_sram_responder: RTL and testbench



---
 rtl/cbus_sram_responder_if.sv | 26 ++
 rtl/cbus_sram_responder.sv | 114 +++++++++++
 tb/tb_cbus_sram_responder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/cbus_sram_responder_if.sv
// Cache-bus request/response bundle between an initiator (master) and a
// memory responder (slave).
interface cbus_sram_responder_if;
   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [3:0]  strobe;
      logic [31:0] data;
      logic [7:0]  len;
      logic [1:0]  burst;   // 2'b00 FIXED, 2'b01 INCR
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;

   cbus_req_t  creq;
   cbus_resp_t cresp;

   modport master (output creq, input cresp);
   modport slave  (input creq, output cresp);
endinterface

// File: rtl/cbus_sram_responder.sv
// Word-addressed SRAM responder on the cache bus: single and FIXED/INCR burst
// reads/writes with byte strobes and a fixed initial wait-state count.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for creq.valid; latches the request on acceptance
// ST_WAIT  | counting down LATENCY wait cycles before the first beat
// ST_BURST | one data beat per cycle, ready=1, last on the final beat
// ST_DONE  | single idle cycle so the initiator can drop valid
module cbus_sram_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic                  clk,
   input  logic                  resetn,
   cbus_sram_responder_if.slave  bus,
   output logic                  busy
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int WW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_BURST, ST_DONE} state_t;

   state_t         state;
   logic           is_write_q;
   logic           incr_q;
   logic [AW-1:0]  idx;
   logic [7:0]     beats_left;
   logic [WW-1:0]  wcnt;
   logic           ready_q;
   logic           last_q;
   logic [31:0]    mem [DEPTH_WORDS];
   logic           beat;

   wire unused_ok = ^{bus.creq.size, bus.creq.addr[31:AW+2], bus.creq.addr[1:0]};

   assign beat = (state == ST_BURST) && bus.creq.valid;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         is_write_q <= 1'b0;
         incr_q     <= 1'b0;
         idx        <= '0;
         beats_left <= '0;
         wcnt       <= '0;
         ready_q    <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.creq.valid) begin
                  is_write_q <= bus.creq.is_write;
                  incr_q     <= (bus.creq.burst == 2'b01);
                  idx        <= bus.creq.addr[AW+1:2];
                  beats_left <= bus.creq.len;
                  wcnt       <= WW'(LATENCY);
                  if (LATENCY == 0) begin
                     state   <= ST_BURST;
                     ready_q <= 1'b1;
                     last_q  <= (bus.creq.len == 8'd0);
                  end else begin
                     state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (!bus.creq.valid) begin
                  state <= ST_IDLE;
               end else begin
                  wcnt <= wcnt - WW'(1);
                  if (wcnt == WW'(1)) begin
                     state   <= ST_BURST;
                     ready_q <= 1'b1;
                     last_q  <= (beats_left == 8'd0);
                  end
               end
            end
            ST_BURST: begin
               if (!bus.creq.valid) begin
                  state   <= ST_IDLE;
                  ready_q <= 1'b0;
                  last_q  <= 1'b0;
               end else begin
                  if (incr_q) idx <= idx + AW'(1);
                  if (beats_left == 8'd0) begin
                     state   <= ST_DONE;
                     ready_q <= 1'b0;
                     last_q  <= 1'b0;
                  end else begin
                     beats_left <= beats_left - 8'd1;
                     last_q     <= (beats_left == 8'd1);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // SRAM array is deliberately outside reset; contents survive resetn.
   always_ff @(posedge clk) begin
      if (beat && is_write_q) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.creq.strobe[b]) mem[idx][8*b +: 8] <= bus.creq.data[8*b +: 8];
         end
      end
   end

   assign bus.cresp.ready = ready_q;
   assign bus.cresp.last  = last_q;
   assign bus.cresp.data  = (ready_q && !is_write_q) ? mem[idx] : 32'd0;
   assign busy            = (state != ST_IDLE);
endmodule

// File: tb/tb_cbus_sram_responder.sv
// Randomized bench for cbus_sram_responder against a word-array memory model.
module tb_cbus_sram_responder;
   localparam int DEPTH = 1024;
   localparam int LAT   = 2;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic busy;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [31:0] model [DEPTH];

   cbus_sram_responder_if bus ();

   cbus_sram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .resetn(resetn), .bus(bus), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle_bus();
      bus.creq.valid    = 1'b0;
      bus.creq.is_write = 1'b0;
      bus.creq.size     = 3'd2;
      bus.creq.addr     = '0;
      bus.creq.strobe   = '0;
      bus.creq.data     = '0;
      bus.creq.len      = '0;
      bus.creq.burst    = 2'b01;
   endtask

   // One full transaction; abort_beat >= 0 drops valid on that beat.
   task automatic xact(input logic [31:0] addr, input bit wr, input int len, input bit incr,
                       input bit rnd, input logic [31:0] wd, input logic [3:0] ws,
                       input int abort_beat);
      int idx;
      logic [31:0] d;
      logic [3:0]  s;
      idx = int'(addr[11:2]);
      @(negedge clk);
      bus.creq.valid    = 1'b1;
      bus.creq.is_write = wr;
      bus.creq.addr     = addr;
      bus.creq.len      = 8'(len);
      bus.creq.burst    = incr ? 2'b01 : 2'b00;
      bus.creq.size     = 3'($urandom_range(0, 2));
      @(posedge clk);
      for (int w = 0; w < LAT; w++) begin
         @(negedge clk);
         check_val("wait_ready", 32'(bus.cresp.ready), 32'd0);
         check_val("wait_busy", 32'(busy), 32'd1);
      end
      for (int b = 0; b <= len; b++) begin
         @(negedge clk);
         check_val("beat_ready", 32'(bus.cresp.ready), 32'd1);
         if (b == abort_beat) begin
            bus.creq.valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check_val("abort_busy", 32'(busy), 32'd0);
            check_val("abort_ready", 32'(bus.cresp.ready), 32'd0);
            idle_bus();
            return;
         end
         check_val("beat_last", 32'(bus.cresp.last), 32'(b == len));
         if (wr) begin
            d = rnd ? $urandom : wd + 32'(b);
            s = rnd ? 4'($urandom_range(0, 15)) : ws;
            bus.creq.data   = d;
            bus.creq.strobe = s;
            check_val("wr_data_zero", bus.cresp.data, 32'd0);
            for (int k = 0; k < 4; k++)
               if (s[k]) model[idx][8*k +: 8] = d[8*k +: 8];
         end else begin
            check_val($sformatf("rd_data[%0d]", idx), bus.cresp.data, model[idx]);
         end
         @(posedge clk);
         if (incr) idx = (idx + 1) % DEPTH;
      end
      @(negedge clk);
      check_val("done_ready", 32'(bus.cresp.ready), 32'd0);
      check_val("done_last", 32'(bus.cresp.last), 32'd0);
      check_val("done_busy", 32'(busy), 32'd1);
      idle_bus();
      @(posedge clk);
      @(negedge clk);
      check_val("idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      int lens [5] = '{0, 1, 3, 7, 15};
      idle_bus();
      repeat (3) @(negedge clk);
      check_val("rst_ready", 32'(bus.cresp.ready), 32'd0);
      check_val("rst_last", 32'(bus.cresp.last), 32'd0);
      check_val("rst_data", bus.cresp.data, 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      resetn = 1'b1;

      for (int i = 0; i < DEPTH / 16; i++)
         xact(32'(i * 64), 1'b1, 15, 1'b1, 1'b1, 32'd0, 4'hF, -1);
      for (int i = 0; i < DEPTH / 16; i++)
         xact(32'(i * 64), 1'b0, 15, 1'b1, 1'b0, 32'd0, 4'h0, -1);

      xact(32'h100, 1'b1, 0, 1'b1, 1'b0, 32'hDEADBEEF, 4'hF, -1);
      xact(32'h100, 1'b0, 0, 1'b1, 1'b0, 32'd0, 4'h0, -1);
      xact(32'h100, 1'b1, 0, 1'b1, 1'b0, 32'h11223344, 4'h5, -1);
      xact(32'h100, 1'b0, 0, 1'b1, 1'b0, 32'd0, 4'h0, -1);

      xact(32'h200, 1'b1, 7, 1'b1, 1'b0, 32'd0, 4'hF, -1);
      xact(32'h200, 1'b0, 7, 1'b1, 1'b0, 32'd0, 4'h0, -1);

      xact(32'hFFC, 1'b0, 3, 1'b1, 1'b0, 32'd0, 4'h0, -1);
      xact(32'h300, 1'b1, 3, 1'b0, 1'b1, 32'd0, 4'hF, -1);
      xact(32'h300, 1'b0, 0, 1'b1, 1'b0, 32'd0, 4'h0, -1);

      xact(32'h400, 1'b1, 3, 1'b1, 1'b0, 32'hA5A50000, 4'hF, 1);
      xact(32'h400, 1'b0, 3, 1'b1, 1'b0, 32'd0, 4'h0, -1);

      // Asynchronous reset during the 3rd beat of an 8-beat read.
      @(negedge clk);
      bus.creq.valid = 1'b1;
      bus.creq.addr  = 32'h200;
      bus.creq.len   = 8'd7;
      bus.creq.burst = 2'b01;
      @(posedge clk);
      repeat (LAT + 3) @(negedge clk);
      check_val("pre_rst_ready", 32'(bus.cresp.ready), 32'd1);
      #2 resetn = 1'b0;
      #1;
      check_val("mid_rst_ready", 32'(bus.cresp.ready), 32'd0);
      check_val("mid_rst_last", 32'(bus.cresp.last), 32'd0);
      check_val("mid_rst_data", bus.cresp.data, 32'd0);
      check_val("mid_rst_busy", 32'(busy), 32'd0);
      idle_bus();
      @(negedge clk);
      resetn = 1'b1;
      xact(32'h100, 1'b0, 0, 1'b1, 1'b0, 32'd0, 4'h0, -1);

      for (int i = 0; i < 40; i++)
         xact($urandom, 1'($urandom_range(0, 1)), lens[$urandom_range(0, 4)],
              1'($urandom_range(0, 1)), 1'b1, 32'd0, 4'hF, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
